// File: rtl/binary_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// valid/ready handshake on both sides; values >= 10**DIGITS raise overflow.
module binary_to_bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [WIDTH-1:0]    r_shreg;
    logic [4*DIGITS-1:0] r_acc;
    logic                r_ovf;
    logic [CW-1:0]       r_cnt;

    logic                w_accept;
    logic                w_last;
    logic [4*DIGITS-1:0] w_adj;

    // Per-digit +3 correction; digits never carry into each other.
    always_comb begin
        w_adj = r_acc;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (r_acc[4*i +: 4] >= 4'd5)
                w_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        w_accept  = 1'b0;
        w_last    = (r_cnt == CW'(1));
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept = 1'b1;
                    w_next   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_last)
                    w_next = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_shreg <= '0;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_shreg <= bin;
                r_acc   <= '0;
                r_ovf   <= 1'b0;
                r_cnt   <= CW'(WIDTH);
            end else if (r_state == S_SHIFT) begin
                // The top digit's MSB after correction is a carry of 10**DIGITS.
                r_acc   <= {w_adj[4*DIGITS-2:0], r_shreg[WIDTH-1]};
                r_shreg <= r_shreg << 1;
                r_ovf   <= r_ovf | w_adj[4*DIGITS-1];
                r_cnt   <= r_cnt - CW'(1);
            end
        end
    end

    assign bcd      = r_acc;
    assign overflow = r_ovf;

endmodule
